// File: rtl/pwm_pkg.sv
// Shared encodings and defaults for the multi-channel PWM generator.
package pwm_pkg;

    localparam int DEF_WIDTH    = 10;
    localparam int DEF_CHANNELS = 2;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    localparam logic [0:0] DIR_UP   = 1'b0;
    localparam logic [0:0] DIR_DOWN = 1'b1;

endpackage

// File: rtl/pwm_multi_if.sv
// Configuration/output bundle of pwm_multi; master drives settings, slave is the PWM block.
interface pwm_multi_if
    import pwm_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
);

    logic [WIDTH-1:0]          period;
    logic [CHANNELS*WIDTH-1:0] cmp;
    logic                      center_mode;
    logic                      load;
    logic [CHANNELS-1:0]       en;
    logic [CHANNELS-1:0]       pwm;
    logic                      period_end;
    logic                      load_pending;

    modport master (
        output period, cmp, center_mode, load, en,
        input  pwm, period_end, load_pending
    );

    modport slave (
        input  period, cmp, center_mode, load, en,
        output pwm, period_end, load_pending
    );

endinterface

// File: rtl/pwm_timebase.sv
// Shared up / up-down counter with combinational boundary flag for the active period.
// Count advances every clock; restart or boundary returns it to 0 counting up.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] period,
    input  logic             mode,
    input  logic             restart,
    output logic [WIDTH-1:0] count,
    output logic             boundary
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [0:0] dir;

    always_comb begin
        boundary = 1'b0;
        if (period == ZERO)
            boundary = 1'b1;
        else if (mode == MODE_EDGE)
            boundary = (count == period);
        else
            // centre mode with P==1 has no down leg, so the top is the boundary
            boundary = ((dir == DIR_DOWN) && (count == ONE)) ||
                       ((period == ONE) && (count == period));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= ZERO;
            dir   <= DIR_UP;
        end else if (restart || boundary) begin
            count <= ZERO;
            dir   <= DIR_UP;
        end else if (mode == MODE_EDGE) begin
            count <= count + ONE;
            dir   <= DIR_UP;
        end else if (dir == DIR_UP) begin
            if (count == period) begin
                count <= period - ONE;
                dir   <= DIR_DOWN;
            end else begin
                count <= count + ONE;
            end
        end else begin
            count <= count - ONE;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with shadowed period/compare/mode committed only at period boundaries.
// Outputs are registered one cycle after the count they reflect; no backpressure.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic        clk,
    input  logic        reset,
    pwm_multi_if.slave  bus
);

    logic [WIDTH-1:0]          p_pend,   p_act;
    logic [CHANNELS*WIDTH-1:0] cmp_pend, cmp_act;
    logic                      mode_pend, mode_act;
    logic                      pend_vld;
    logic [CHANNELS-1:0]       pwm_q, hit;
    logic                      period_end_q;
    logic [WIDTH-1:0]          count;
    logic                      boundary;
    logic                      commit;

    assign commit = boundary && pend_vld;

    pwm_timebase #(.WIDTH(WIDTH)) u_timebase (
        .clk      (clk),
        .reset    (reset),
        .period   (p_act),
        .mode     (mode_act),
        .restart  (commit),
        .count    (count),
        .boundary (boundary)
    );

    // Commit uses the pending values as they stood before this cycle's load
    always_ff @(posedge clk) begin
        if (reset) begin
            p_pend    <= '0;
            cmp_pend  <= '0;
            mode_pend <= MODE_EDGE;
            pend_vld  <= 1'b0;
            p_act     <= '0;
            cmp_act   <= '0;
            mode_act  <= MODE_EDGE;
        end else begin
            if (commit) begin
                p_act    <= p_pend;
                cmp_act  <= cmp_pend;
                mode_act <= mode_pend;
            end
            if (bus.load) begin
                p_pend    <= bus.period;
                cmp_pend  <= bus.cmp;
                mode_pend <= bus.center_mode;
                pend_vld  <= 1'b1;
            end else if (commit) begin
                pend_vld  <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_cmp
        assign hit[i] = (count < cmp_act[i*WIDTH +: WIDTH]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_q        <= '0;
            period_end_q <= 1'b0;
        end else begin
            pwm_q        <= bus.en & hit;
            period_end_q <= boundary;
        end
    end

    assign bus.pwm          = pwm_q;
    assign bus.period_end   = period_end_q;
    assign bus.load_pending = pend_vld;

endmodule
